rect_state_seq: RTL and testbench

- Parametrised cipher-state register with its own round sequencer. It is the next generation of the round-based state register: it loads a plaintext/state word, iterates over the round-function feedback for a configurable number of rounds, and presents the result through a valid/ack handshake.
- It sits between the input interface and the combinational round function in the round-based RECTANGLE core.
- Row slicing of the state is generic over row width and row count.

---
 rtl/rect_state_seq.sv | 86 ++++++++
 tb/tb_rect_state_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rect_state_seq.sv
// Cipher-state register with its own round sequencer: load a block, iterate the
// external round function for ROUNDS enabled cycles, then hold the result until acked.
module rect_state_seq #(
  parameter int ROW_W  = 16,
  parameter int ROWS   = 4,
  parameter int ROUNDS = 25,
  parameter int CNT_W  = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load,
  input  logic [ROW_W*ROWS-1:0]   iv_data_in,
  output logic                    o_ready,
  input  logic [ROW_W*ROWS-1:0]   iv_round_data,
  input  logic                    i_en,
  output logic [ROW_W*ROWS-1:0]   ov_rows,
  output logic [CNT_W-1:0]        ov_round_cnt,
  output logic                    o_last_round,
  output logic                    o_valid,
  input  logic                    i_ack,
  output logic [1:0]              o_state_dbg
);

  localparam int STATE_W = ROW_W * ROWS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Handshakes: a load transfers on an edge where i_load && o_ready; a result
  // transfers on an edge where o_valid && i_ack. Requests outside those
  // windows are dropped, never queued.

  logic [1:0]         fsm_q;
  logic [STATE_W-1:0] state_q;
  logic [CNT_W-1:0]   cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (i_load) begin
            state_q <= iv_data_in;
            cnt_q   <= '0;
            fsm_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_en) begin
            state_q <= iv_round_data;
            // Counter parks on the last index so it never exceeds ROUNDS-1.
            if (cnt_q == LAST_CNT) begin
              fsm_q <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (i_ack) begin
            cnt_q <= '0;
            fsm_q <= ST_IDLE;
          end
        end
        default: begin
          fsm_q <= ST_IDLE;
          cnt_q <= '0;
        end
      endcase
    end
  end

  // Every output is a decode of registered state only.
  assign o_ready      = (fsm_q == ST_IDLE);
  assign o_valid      = (fsm_q == ST_DONE);
  assign o_last_round = (fsm_q == ST_RUN) && (cnt_q == LAST_CNT);
  assign ov_rows      = state_q;
  assign ov_round_cnt = cnt_q;
  assign o_state_dbg  = fsm_q;

endmodule

// File: tb/tb_rect_state_seq.sv
// Directed bench for rect_state_seq: default instance (64-bit, 25 rounds) and a
// 128-bit single-round instance, with a queue of expected final states.
module tb_rect_state_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        rst, load, en, ack, ready, last, valid;
  logic [63:0] data_in, round_data, rows;
  logic [4:0]  cnt;
  logic [1:0]  st;

  // ROW_W=32, ROWS=4, ROUNDS=1, CNT_W=1 instance
  logic         load1, en1, ack1, ready1, last1, valid1;
  logic [127:0] data_in1, round_data1, rows1;
  logic [0:0]   cnt1;
  logic [1:0]   st1;

  // Round-function stand-in: next state = state + 1
  assign round_data  = rows + 64'd1;
  assign round_data1 = rows1 + 128'd1;

  rect_state_seq dut (
    .i_clk(clk), .i_rst(rst), .i_load(load), .iv_data_in(data_in), .o_ready(ready),
    .iv_round_data(round_data), .i_en(en), .ov_rows(rows), .ov_round_cnt(cnt),
    .o_last_round(last), .o_valid(valid), .i_ack(ack), .o_state_dbg(st)
  );

  rect_state_seq #(.ROW_W(32), .ROWS(4), .ROUNDS(1), .CNT_W(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_load(load1), .iv_data_in(data_in1), .o_ready(ready1),
    .iv_round_data(round_data1), .i_en(en1), .ov_rows(rows1), .ov_round_cnt(cnt1),
    .o_last_round(last1), .o_valid(valid1), .i_ack(ack1), .o_state_dbg(st1)
  );

  logic [63:0]  exp_q[$];
  logic [127:0] exp1_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Bounded wait for o_valid on the default instance.
  task automatic wait_valid(input string tag, input int max_edges);
    int n = 0;
    while (!valid && n < max_edges) begin
      tick();
      n++;
    end
    check(tag, {127'd0, valid}, 128'd1);
  endtask

  initial begin
    logic [63:0] prev_rows, hold_rows, d;
    logic [4:0]  prev_cnt, exp_cnt;
    logic [127:0] d1;

    rst = 1'b1; load = 1'b1; data_in = 64'hFFFF_FFFF_FFFF_FFFF; en = 1'b0; ack = 1'b0;
    load1 = 1'b1; data_in1 = '1; en1 = 1'b0; ack1 = 1'b0;

    // Reset held 2 cycles with load requests pending: nothing may load.
    tick();
    check("rst_rows_e1", rows, 0);
    tick();
    check("rst_rows_e2", rows, 0);
    rst = 1'b0; load = 1'b0; load1 = 1'b0;
    check("rst_ready", ready, 1);
    check("rst_valid", valid, 0);
    check("rst_last", last, 0);
    check("rst_cnt", cnt, 0);
    check("rst_state", st, 0);
    check("rst1_rows", rows1, 0);
    check("rst1_ready", ready1, 1);

    // Load and run with i_en held high.
    data_in = 64'h0123_4567_89AB_CDEF; load = 1'b1; en = 1'b1;
    exp_q.push_back(64'h0123_4567_89AB_CDEF + 64'd25);
    tick();
    load = 1'b0;
    check("run_ready_low", ready, 0);
    for (int e = 1; e <= 25; e++) begin
      check("run_cnt", cnt, e - 1);
      check("run_last", last, (e - 1) == 24);
      check("run_valid_low", valid, 0);
      tick();
    end
    check("run_valid", valid, 1);
    check("run_last_done", last, 0);
    check("run_rows", rows, exp_q.pop_front());
    check("run_row0", rows[15:0], 16'hCE08);

    // Result hold: no ack for 10 cycles while loads keep arriving.
    hold_rows = rows;
    for (int i = 0; i < 10; i++) begin
      load = 1'b1; data_in = {$urandom, $urandom};
      tick();
      check("hold_valid", valid, 1);
      check("hold_rows", rows, hold_rows);
      check("hold_ready", ready, 0);
    end
    load = 1'b0; ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_ready", ready, 1);
    check("ack_valid", valid, 0);
    check("ack_cnt", cnt, 0);
    check("ack_rows_kept", rows, hold_rows);

    // Back-to-back: ack then load on consecutive edges.
    en = 1'b1;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    d = {$urandom, $urandom};
    data_in = d; load = 1'b1;
    exp_q.push_back(d + 64'd25);
    tick();
    load = 1'b0;
    check("b2b_cnt0", cnt, 0);
    check("b2b_rows0", rows, d);
    wait_valid("b2b_timeout", 40);
    check("b2b_rows", rows, exp_q.pop_front());
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // Stall: i_en alternates 1 (load edge), 0, 1, 0, ...
    data_in = 64'h0123_4567_89AB_CDEF; load = 1'b1; en = 1'b1;
    exp_q.push_back(64'h0123_4567_89AB_CDEF + 64'd25);
    tick();
    load = 1'b0;
    exp_cnt = 5'd0;
    for (int e = 1; e <= 50; e++) begin
      en = (e % 2 == 0);
      prev_rows = rows;
      prev_cnt  = cnt;
      tick();
      if (en && exp_cnt != 5'd24) exp_cnt = exp_cnt + 5'd1;
      if (!en) begin
        check("stall_rows_frozen", rows, prev_rows);
        check("stall_cnt_frozen", cnt, prev_cnt);
      end
      check("stall_cnt", cnt, exp_cnt);
      check("stall_valid", valid, e == 50);
    end
    check("stall_rows", rows, exp_q.pop_front());
    ack = 1'b1; en = 1'b1;
    tick();
    ack = 1'b0;

    // Reset at cnt = 12 discards the block.
    data_in = {$urandom, $urandom}; load = 1'b1;
    exp_q.push_back(data_in + 64'd25);
    tick();
    load = 1'b0;
    for (int e = 0; e < 12; e++) tick();
    check("mid_cnt12", cnt, 12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("mid_rows", rows, 0);
    check("mid_cnt", cnt, 0);
    check("mid_ready", ready, 1);
    check("mid_valid", valid, 0);
    check("mid_last", last, 0);
    for (int e = 0; e < 20; e++) begin
      tick();
      check("mid_no_valid", valid, 0);
    end

    // Single-round, 128-bit instance.
    d1 = {$urandom, $urandom, $urandom, $urandom};
    data_in1 = d1; load1 = 1'b1; en1 = 1'b1;
    exp1_q.push_back(d1 + 128'd1);
    tick();
    load1 = 1'b0;
    check("r1_last", last1, 1);
    check("r1_valid_low", valid1, 0);
    check("r1_cnt", cnt1, 0);
    tick();
    check("r1_valid", valid1, 1);
    check("r1_last_done", last1, 0);
    check("r1_rows", rows1, exp1_q.pop_front());

    check("queues_empty", exp_q.size() + exp1_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
